// File: rtl/gt_rx_link_sequencer.sv
// GT RX link bring-up / supervision sequencer.
// Drives comma realignment and RX elastic-buffer reset, holds TX on IDLE
// until the link is up, then watches for alignment loss and buffer
// over/underflow. A fault before UP costs one retry, and when the retries
// run out the sequencer latches FAILED. A fault while UP only bumps the
// error counter and re-runs bring-up.
module gt_rx_link_sequencer #(
  parameter int g_ALIGN_TIMEOUT    = 4096,
  parameter int g_BLIND_PERIOD     = 10,
  parameter int g_BUF_RESET_CYCLES = 16,
  parameter int g_MAX_RETRIES      = 8
) (
  input  logic        usrclk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic        gt_ready_i,
  input  logic        rx_aligned_i,
  input  logic [2:0]  rx_bufstatus_i,
  output logic        rx_realign_o,
  output logic        rx_buf_reset_o,
  output logic        tx_force_idle_o,
  output logic        link_up_o,
  output logic        failed_o,
  output logic [2:0]  state_o,
  output logic [3:0]  retry_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam int c_TMAX0 = (g_ALIGN_TIMEOUT > g_BUF_RESET_CYCLES) ? g_ALIGN_TIMEOUT : g_BUF_RESET_CYCLES;
  localparam int c_TMAX  = (c_TMAX0 > g_BLIND_PERIOD) ? c_TMAX0 : g_BLIND_PERIOD;
  localparam int c_TW    = $clog2(c_TMAX + 1);

  localparam logic [c_TW-1:0] c_ALIGN_LAST = c_TW'(g_ALIGN_TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_BLIND_LAST = c_TW'(g_BLIND_PERIOD - 1);
  localparam logic [c_TW-1:0] c_BUF_LAST   = c_TW'(g_BUF_RESET_CYCLES - 1);
  // Buffer status is not trusted until BLIND has run this many cycles.
  localparam logic [c_TW-1:0] c_BUF_IGNORE = c_TW'(2);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_REALIGN    = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_BLIND      = 3'd4,
    ST_UP         = 3'd5,
    ST_BUF_RESET  = 3'd6,
    ST_FAILED     = 3'd7
  } state_t;

  state_t          state;
  logic [c_TW-1:0] timer;
  logic            buf_err;
  logic            fault_attempt;
  logic            fault_up;
  logic            last_retry;

  // Only bit 2 (over/underflow) matters; the low status bits are not used.
  logic unused_bufstatus;
  assign unused_bufstatus = ^rx_bufstatus_i[1:0];

  assign buf_err    = rx_bufstatus_i[2];
  assign last_retry = (32'(retry_cnt_o) + 32'd1) == 32'(g_MAX_RETRIES);
  assign state_o    = state;

  // Fault detection for the current cycle: an attempt fault during bring-up, or a link fault while UP.
  always_comb begin
    fault_attempt = 1'b0;
    fault_up      = 1'b0;
    case (state)
      ST_WAIT_ALIGN: fault_attempt = !rx_aligned_i && (timer == c_ALIGN_LAST);
      ST_BLIND:      fault_attempt = !rx_aligned_i || (buf_err && (timer >= c_BUF_IGNORE));
      ST_UP:         fault_up      = !rx_aligned_i || buf_err;
      default: ;
    endcase
  end

  // Sequencer FSM with registered outputs and counters.
  always_ff @(posedge usrclk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      timer           <= '0;
      rx_realign_o    <= 1'b0;
      rx_buf_reset_o  <= 1'b0;
      tx_force_idle_o <= 1'b1;
      link_up_o       <= 1'b0;
      failed_o        <= 1'b0;
      retry_cnt_o     <= '0;
      err_cnt_o       <= '0;
    end else begin
      if (!enable_i) begin
        state           <= ST_IDLE;
        timer           <= '0;
        rx_realign_o    <= 1'b0;
        rx_buf_reset_o  <= 1'b0;
        tx_force_idle_o <= 1'b1;
        link_up_o       <= 1'b0;
        failed_o        <= 1'b0;
      end else if (fault_attempt) begin
        timer        <= '0;
        rx_realign_o <= 1'b0;
        if (last_retry) begin
          state          <= ST_FAILED;
          rx_buf_reset_o <= 1'b0;
          failed_o       <= 1'b1;
        end else begin
          state          <= ST_BUF_RESET;
          rx_buf_reset_o <= 1'b1;
          retry_cnt_o    <= retry_cnt_o + 4'd1;
        end
      end else if (fault_up) begin
        state           <= ST_BUF_RESET;
        timer           <= '0;
        rx_buf_reset_o  <= 1'b1;
        link_up_o       <= 1'b0;
        tx_force_idle_o <= 1'b1;
        if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_WAIT_READY;
            timer <= '0;
          end
          ST_WAIT_READY: begin
            if (gt_ready_i) begin
              state          <= ST_BUF_RESET;
              timer          <= '0;
              rx_buf_reset_o <= 1'b1;
            end
          end
          ST_BUF_RESET: begin
            if (timer == c_BUF_LAST) begin
              state          <= ST_REALIGN;
              timer          <= '0;
              rx_buf_reset_o <= 1'b0;
              rx_realign_o   <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_REALIGN: begin
            state <= ST_WAIT_ALIGN;
            timer <= '0;
          end
          ST_WAIT_ALIGN: begin
            if (rx_aligned_i) begin
              state        <= ST_BLIND;
              timer        <= '0;
              rx_realign_o <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_BLIND: begin
            if (timer == c_BLIND_LAST) begin
              state           <= ST_UP;
              timer           <= '0;
              link_up_o       <= 1'b1;
              tx_force_idle_o <= 1'b0;
              retry_cnt_o     <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_UP: ;
          ST_FAILED: begin
            if (clear_i) begin
              state    <= ST_IDLE;
              timer    <= '0;
              failed_o <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      // Clear wins over any increment made above in the same cycle.
      if (clear_i) begin
        retry_cnt_o <= '0;
        err_cnt_o   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gt_rx_link_sequencer.sv
// Scoreboard bench for gt_rx_link_sequencer: each step pushes the expected
// output snapshot when inputs are driven and pops/compares after the edge.
module tb_gt_rx_link_sequencer;

  logic        usrclk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        gt_ready_i = 1'b0;
  logic        rx_aligned_i = 1'b0;
  logic [2:0]  rx_bufstatus_i = 3'b000;
  logic        rx_realign_o, rx_buf_reset_o, tx_force_idle_o, link_up_o, failed_o;
  logic [2:0]  state_o;
  logic [3:0]  retry_cnt_o;
  logic [15:0] err_cnt_o;

  localparam logic [2:0] IDLE = 3'd0, WRDY = 3'd1, RALN = 3'd2, WALN = 3'd3,
                         BLND = 3'd4, UP = 3'd5, BRST = 3'd6, FAIL_ST = 3'd7;

  gt_rx_link_sequencer dut (
    .usrclk_i(usrclk_i), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
    .gt_ready_i(gt_ready_i), .rx_aligned_i(rx_aligned_i), .rx_bufstatus_i(rx_bufstatus_i),
    .rx_realign_o(rx_realign_o), .rx_buf_reset_o(rx_buf_reset_o),
    .tx_force_idle_o(tx_force_idle_o), .link_up_o(link_up_o), .failed_o(failed_o),
    .state_o(state_o), .retry_cnt_o(retry_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 usrclk_i = ~usrclk_i;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic        rl, br, idl, up, fl;
    logic [3:0]  rt;
    logic [15:0] er;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] st, input logic rl, input logic br,
                          input logic idl, input logic up, input logic fl,
                          input logic [3:0] rt, input logic [15:0] er);
    exp_t e;
    e.tag = tag; e.st = st; e.rl = rl; e.br = br; e.idl = idl; e.up = up; e.fl = fl;
    e.rt = rt; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".state"},  32'(state_o),         32'(e.st));
    chk({e.tag, ".realign"},32'(rx_realign_o),    32'(e.rl));
    chk({e.tag, ".bufrst"}, 32'(rx_buf_reset_o),  32'(e.br));
    chk({e.tag, ".txidle"}, 32'(tx_force_idle_o), 32'(e.idl));
    chk({e.tag, ".linkup"}, 32'(link_up_o),       32'(e.up));
    chk({e.tag, ".failed"}, 32'(failed_o),        32'(e.fl));
    chk({e.tag, ".retry"},  32'(retry_cnt_o),     32'(e.rt));
    chk({e.tag, ".err"},    32'(err_cnt_o),       32'(e.er));
  endtask

  task automatic tick();
    @(posedge usrclk_i);
    #1;
  endtask

  // Push expectation for the next edge, clock it, compare.
  task automatic step(input string tag, input logic [2:0] st, input logic rl, input logic br,
                      input logic idl, input logic up, input logic fl,
                      input logic [3:0] rt, input logic [15:0] er);
    push_exp(tag, st, rl, br, idl, up, fl, rt, er);
    tick();
    pop_cmp();
  endtask

  // From BUF_RESET just entered: rest of the buffer reset, REALIGN, first WAIT_ALIGN cycle.
  task automatic to_wait_align(input string tag, input logic [3:0] rt, input logic [15:0] er);
    for (int i = 0; i < 15; i++) step({tag, ".brst"}, BRST, 0, 1, 1, 0, 0, rt, er);
    rx_aligned_i = 1'b0;
    step({tag, ".raln"}, RALN, 1, 0, 1, 0, 0, rt, er);
    step({tag, ".waln"}, WALN, 1, 0, 1, 0, 0, rt, er);
  endtask

  // From some BLIND cycle: n more BLIND cycles, then UP with retries cleared.
  task automatic blind_to_up(input string tag, input int n, input logic [3:0] rt, input logic [15:0] er);
    for (int i = 0; i < n; i++) step({tag, ".blnd"}, BLND, 0, 0, 1, 0, 0, rt, er);
    step({tag, ".up"}, UP, 0, 0, 0, 1, 0, 4'd0, er);
  endtask

  // Clock until state leaves st or the budget runs out; returns cycles taken.
  task automatic wait_leave(input logic [2:0] st, input int budget, output int n);
    n = 0;
    while (state_o == st && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    // Reset state
    tick(); tick();
    push_exp("reset", IDLE, 0, 0, 1, 0, 0, 4'd0, 16'd0);
    pop_cmp();

    // Initial bring-up, alignment 5 cycles after REALIGN
    rst_i = 1'b0; enable_i = 1'b1;
    step("t1.wrdy0", WRDY, 0, 0, 1, 0, 0, 0, 0);
    step("t1.wrdy1", WRDY, 0, 0, 1, 0, 0, 0, 0);
    gt_ready_i = 1'b1;
    step("t1.brst0", BRST, 0, 1, 1, 0, 0, 0, 0);
    to_wait_align("t1", 0, 0);
    for (int i = 0; i < 3; i++) step("t1.waln_hold", WALN, 1, 0, 1, 0, 0, 0, 0);
    rx_aligned_i = 1'b1;
    step("t1.blnd0", BLND, 0, 0, 1, 0, 0, 0, 0);
    blind_to_up("t1", 9, 0, 0);

    // UP buffer fault -> err count, relink without retry increment
    rx_bufstatus_i = 3'b110;
    step("t2.fault", BRST, 0, 1, 1, 0, 0, 0, 16'd1);
    rx_bufstatus_i = 3'b000;
    to_wait_align("t2", 0, 1);
    rx_aligned_i = 1'b1;
    step("t2.blnd0", BLND, 0, 0, 1, 0, 0, 0, 1);
    blind_to_up("t2", 9, 0, 1);

    // Alignment loss while UP, then alignment drops inside BLIND
    rx_aligned_i = 1'b0;
    step("t6.upfault", BRST, 0, 1, 1, 0, 0, 0, 16'd2);
    to_wait_align("t6", 0, 2);
    rx_aligned_i = 1'b1;
    step("t6.blnd0", BLND, 0, 0, 1, 0, 0, 0, 2);
    for (int i = 0; i < 3; i++) step("t6.blnd", BLND, 0, 0, 1, 0, 0, 0, 2);
    rx_aligned_i = 1'b0;
    step("t6.blndfault", BRST, 0, 1, 1, 0, 0, 4'd1, 2);
    to_wait_align("t6b", 1, 2);
    rx_aligned_i = 1'b1;
    step("t6b.blnd0", BLND, 0, 0, 1, 0, 0, 1, 2);
    // Buffer status ignored during the first two BLIND cycles
    rx_bufstatus_i = 3'b100;
    step("t6b.ign0", BLND, 0, 0, 1, 0, 0, 1, 2);
    step("t6b.ign1", BLND, 0, 0, 1, 0, 0, 1, 2);
    rx_bufstatus_i = 3'b000;
    blind_to_up("t6b", 7, 1, 2);

    // enable_i low in WAIT_ALIGN -> IDLE, counters kept
    rx_aligned_i = 1'b0;
    step("t5.upfault", BRST, 0, 1, 1, 0, 0, 0, 16'd3);
    to_wait_align("t5", 0, 3);
    enable_i = 1'b0;
    step("t5.dis", IDLE, 0, 0, 1, 0, 0, 0, 3);
    enable_i = 1'b1;
    step("t5.wrdy", WRDY, 0, 0, 1, 0, 0, 0, 3);
    step("t5.brst0", BRST, 0, 1, 1, 0, 0, 0, 3);
    to_wait_align("t5b", 0, 3);
    rx_aligned_i = 1'b1;
    step("t5b.blnd0", BLND, 0, 0, 1, 0, 0, 0, 3);
    blind_to_up("t5b", 9, 0, 3);

    // clear_i together with an UP fault: transition happens, counters read 0
    rx_bufstatus_i = 3'b100; clear_i = 1'b1;
    step("clr.fault", BRST, 0, 1, 1, 0, 0, 0, 16'd0);
    rx_bufstatus_i = 3'b000; clear_i = 1'b0;
    to_wait_align("t3", 0, 0);

    // Alignment timeouts until FAILED
    for (int k = 0; k < 8; k++) begin
      if (k < 7) push_exp("t3.timeout", BRST, 0, 1, 1, 0, 0, 4'(k + 1), 0);
      else       push_exp("t3.failed", FAIL_ST, 0, 0, 1, 0, 1, 4'd7, 0);
      wait_leave(WALN, 5000, n);
      chk("t3.timeout_cycles", 32'(n), 32'd4096);
      pop_cmp();
      if (k < 7) to_wait_align("t3.re", 4'(k + 1), 0);
    end
    step("t3.hold", FAIL_ST, 0, 0, 1, 0, 1, 4'd7, 0);

    // clear_i leaves FAILED, then a normal bring-up
    clear_i = 1'b1;
    step("t4.clr", IDLE, 0, 0, 1, 0, 0, 0, 0);
    clear_i = 1'b0;
    step("t4.wrdy", WRDY, 0, 0, 1, 0, 0, 0, 0);
    step("t4.brst0", BRST, 0, 1, 1, 0, 0, 0, 0);
    to_wait_align("t4", 0, 0);
    rx_aligned_i = 1'b1;
    step("t4.blnd0", BLND, 0, 0, 1, 0, 0, 0, 0);
    blind_to_up("t4", 9, 0, 0);

    // Asynchronous reset mid-cycle while UP
    #2 rst_i = 1'b1;
    #1;
    push_exp("arst", IDLE, 0, 0, 1, 0, 0, 0, 0);
    pop_cmp();
    step("arst.hold", IDLE, 0, 0, 1, 0, 0, 0, 0);
    rst_i = 1'b0;
    step("arst.rel", WRDY, 0, 0, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
